// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: two read ports, two write ports, a reserve port
// and the busy-count output. The register file is the slave; the driver is the master.
interface reg_file_sb_if #(
    parameter int W = 8,
    parameter int D = 4
);
    logic [D-1:0] raddrA;
    logic [D-1:0] raddrB;
    logic [W-1:0] data_outA;
    logic [W-1:0] data_outB;
    logic         busyA;
    logic         busyB;
    logic         write_en0;
    logic         write_en1;
    logic [D-1:0] waddr0;
    logic [D-1:0] waddr1;
    logic [W-1:0] data_in0;
    logic [W-1:0] data_in1;
    logic         rsv_en;
    logic [D-1:0] rsv_addr;
    logic [D:0]   busy_cnt;

    modport slave (
        input  raddrA, raddrB, write_en0, write_en1, waddr0, waddr1,
               data_in0, data_in1, rsv_en, rsv_addr,
        output data_outA, data_outB, busyA, busyB, busy_cnt
    );

    modport master (
        output raddrA, raddrB, write_en0, write_en1, waddr0, waddr1,
               data_in0, data_in1, rsv_en, rsv_addr,
        input  data_outA, data_outB, busyA, busyB, busy_cnt
    );
endinterface

// File: rtl/reg_file_sb.sv
// Two-read/two-write register file with a per-register busy scoreboard,
// optional same-cycle write forwarding and an optional hardwired zero register.
module reg_file_sb #(
    parameter int W        = 8,
    parameter int D        = 4,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic           CLK,
    input  logic           reset,
    reg_file_sb_if.slave   bus
);
    localparam int DEPTH = 1 << D;

    logic [W-1:0]     regs_q [DEPTH];
    logic [W-1:0]     regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [D:0]       busy_cnt_q;
    logic [D:0]       busy_cnt_d;

    logic wrEff0;
    logic wrEff1;
    logic rsvEff;

    logic [D-1:0] rdAddr [2];
    logic [W-1:0] rdData [2];
    logic         rdBusy [2];

    function automatic logic isZeroReg(input logic [D-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign wrEff0 = bus.write_en0 && !reset && !isZeroReg(bus.waddr0);
    assign wrEff1 = bus.write_en1 && !reset && !isZeroReg(bus.waddr1);
    assign rsvEff = bus.rsv_en    && !reset && !isZeroReg(bus.rsv_addr);

    // Port 1 is applied after port 0 so it wins a same-address collision;
    // the reservation is applied last so it wins over a write's busy clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wrEff0) begin
            regs_d[bus.waddr0] = bus.data_in0;
            busy_d[bus.waddr0] = 1'b0;
        end
        if (wrEff1) begin
            regs_d[bus.waddr1] = bus.data_in1;
            busy_d[bus.waddr1] = 1'b0;
        end
        if (rsvEff) begin
            busy_d[bus.rsv_addr] = 1'b1;
        end
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + {{D{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign rdAddr[0] = bus.raddrA;
    assign rdAddr[1] = bus.raddrB;

    // A forwarded write hides a stale busy bit unless a reservation targets
    // the same register this cycle, in which case the stored bit is shown.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdData[p] = regs_q[rdAddr[p]];
            rdBusy[p] = busy_q[rdAddr[p]];
            if (BYPASS != 0) begin
                if (wrEff1 && (bus.waddr1 == rdAddr[p])) begin
                    rdData[p] = bus.data_in1;
                end else if (wrEff0 && (bus.waddr0 == rdAddr[p])) begin
                    rdData[p] = bus.data_in0;
                end
                if (((wrEff1 && (bus.waddr1 == rdAddr[p])) ||
                     (wrEff0 && (bus.waddr0 == rdAddr[p]))) &&
                    !(rsvEff && (bus.rsv_addr == rdAddr[p]))) begin
                    rdBusy[p] = 1'b0;
                end
            end
            if (isZeroReg(rdAddr[p])) begin
                rdData[p] = '0;
                rdBusy[p] = 1'b0;
            end
        end
    end

    assign bus.data_outA = rdData[0];
    assign bus.data_outB = rdData[1];
    assign bus.busyA     = rdBusy[0];
    assign bus.busyB     = rdBusy[1];
    assign bus.busy_cnt  = busy_cnt_q;
endmodule
